// File: rtl/dump_pkg.sv
// Shared encodings and constants for the RAM dump reader and related address walkers.
package dump_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } dump_state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam logic        MEM_RW_READ   = 1'b0;
    localparam logic        MEM_SIZE_WORD = 1'b1;

endpackage

// File: rtl/dump_addr_ctr.sv
// Loadable word-stride byte-address counter with a combinational last-address compare.
module dump_addr_ctr
    import dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              is_last_c
);

    // Load has priority; the caller never increments past last_addr, so no wrap occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_addr;
        end else if (inc) begin
            addr <= addr + ADDR_W'(WORD_BYTES);
        end
    end

    assign is_last_c = (addr == last_addr);

endmodule

// File: rtl/ram_dump_reader.sv
// Walks a word-aligned RAM window and streams each word with its byte address over valid/ready.
// Optional build macro DUMP_SKIP_ZERO_EN: all-zero words are skipped and not counted.
module ram_dump_reader
    import dump_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned END_ADDR   = 252
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic              mem_size,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       mem_data_out,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] words_sent
);

    dump_state_e       state;
    logic [ADDR_W-1:0] cur;
    logic              is_last;
    logic              skip_word;
    logic              ctr_load;
    logic              ctr_inc;

    assign mem_read_write = MEM_RW_READ;
    assign mem_size       = MEM_SIZE_WORD;
    assign mem_address    = cur;

`ifdef DUMP_SKIP_ZERO_EN
    assign skip_word = (mem_data_out == 32'h0);
`else
    assign skip_word = 1'b0;
`endif

    // Counter moves on an accepted non-last word, or on a skipped non-last word.
    always_comb begin
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        if (state == IDLE && start) begin
            ctr_load = 1'b1;
        end
        if (!abort && !is_last) begin
            if (state == PRESENT && dump_ready) begin
                ctr_inc = 1'b1;
            end
            if (state == ISSUE && skip_word) begin
                ctr_inc = 1'b1;
            end
        end
    end

    dump_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .inc       (ctr_inc),
        .load_addr (ADDR_W'(START_ADDR)),
        .last_addr (ADDR_W'(END_ADDR)),
        .addr      (cur),
        .is_last_c (is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_enable <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ISSUE;
                        mem_enable <= 1'b1;
                        busy       <= 1'b1;
                        words_sent <= '0;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state      <= IDLE;
                        mem_enable <= 1'b0;
                        busy       <= 1'b0;
                    end else if (skip_word) begin
                        // Skipped word: stay in ISSUE on the next address, or finish.
                        if (is_last) begin
                            state      <= DONE;
                            mem_enable <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else begin
                        state      <= PRESENT;
                        mem_enable <= 1'b0;
                        dump_valid <= 1'b1;
                        dump_data  <= mem_data_out;
                        dump_addr  <= cur;
                    end
                end
                PRESENT: begin
                    if (abort) begin
                        state      <= IDLE;
                        dump_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        words_sent <= words_sent + 1'b1;
                        if (is_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            mem_enable <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Self-checking bench for ram_dump_reader: window 0..8 instance plus a single-word 252 instance.
module tb_ram_dump_reader;

    localparam int unsigned ADDR_W = 8;
`ifdef DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [64];

    logic              rst_n;
    logic              start, abort, dump_ready;
    logic              mem_enable, mem_read_write, mem_size;
    logic [ADDR_W-1:0] mem_address, dump_addr;
    logic [31:0]       mem_data_out, dump_data;
    logic              dump_valid, busy, done;
    logic [ADDR_W-2:0] words_sent;

    logic              start2, abort2, dump_ready2;
    logic              mem_enable2, mem_read_write2, mem_size2;
    logic [ADDR_W-1:0] mem_address2, dump_addr2;
    logic [31:0]       mem_data_out2, dump_data2;
    logic              dump_valid2, busy2, done2;
    logic [ADDR_W-2:0] words_sent2;

    assign mem_data_out  = ram[mem_address[7:2]];
    assign mem_data_out2 = ram[mem_address2[7:2]];

    ram_dump_reader #(.ADDR_W(ADDR_W), .START_ADDR(0), .END_ADDR(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mem_enable(mem_enable), .mem_read_write(mem_read_write), .mem_size(mem_size),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_addr(dump_addr), .busy(busy), .done(done), .words_sent(words_sent)
    );

    ram_dump_reader #(.ADDR_W(ADDR_W), .START_ADDR(252), .END_ADDR(252)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .mem_enable(mem_enable2), .mem_read_write(mem_read_write2), .mem_size(mem_size2),
        .mem_address(mem_address2), .mem_data_out(mem_data_out2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready2), .dump_data(dump_data2),
        .dump_addr(dump_addr2), .busy(busy2), .done(done2), .words_sent(words_sent2)
    );

    int unsigned exp_addr [$];
    logic [31:0] exp_data [$];
    int unsigned obs_addr [$];
    logic [31:0] obs_data [$];
    int          obs_cyc  [$];
    int          done_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: every word of window 0..8 in address order, zero words dropped when skipping.
    task automatic build_expected();
        exp_addr.delete();
        exp_data.delete();
        for (int a = 0; a <= 8; a += 4) begin
            if (!SKIP || ram[a/4] != 32'h0) begin
                exp_addr.push_back(a);
                exp_data.push_back(ram[a/4]);
            end
        end
    endtask

    // Pulse start on dut and record every handshake until done, with random ready.
    task automatic run_collect(input int pct);
        bit seen;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cnt = 0;
        seen = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            dump_ready = (int'($urandom_range(99)) < pct);
            if (dump_valid && dump_ready) begin
                obs_addr.push_back(int'(dump_addr));
                obs_data.push_back(dump_data);
                obs_cyc.push_back(cyc);
            end
            step();
            if (done) begin
                done_cnt++;
                seen = 1'b1;
            end
        end
        dump_ready = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL collect_timeout: done=%0b required done pulse within 400 cycles", done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL after_done: busy=%0b done=%0b required 0/0", busy, done);
        end
    endtask

    task automatic compare_beats(input string tag);
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL %s_beats: got %0d required %0d", tag, obs_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    failures++;
                    $display("FAIL %s_beat%0d: got %0d/%h required %0d/%h", tag, i,
                             obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (words_sent !== 7'(exp_addr.size())) begin
            failures++;
            $display("FAIL %s_words_sent: got %0d required %0d", tag, words_sent, exp_addr.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (mem_enable !== 1'b0 || dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            words_sent !== '0 || mem_address !== '0 || dump_data !== '0 || dump_addr !== '0 ||
            mem_size !== 1'b1 || mem_read_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: en=%0b v=%0b busy=%0b done=%0b ws=%0d addr=%0d size=%0b required all 0, size 1",
                     mem_enable, dump_valid, busy, done, words_sent, mem_address, mem_size);
        end
    endtask

    task automatic test_basic();
        ram[0] = 32'hDEADBEEF;
        ram[1] = 32'h00000000;
        ram[2] = 32'h12345678;
        build_expected();
        run_collect(100);
        compare_beats("basic");
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done_count: got %0d required 1", done_cnt);
        end
        for (int i = 1; i < obs_cyc.size() && i < exp_addr.size(); i++) begin
            int req;
            req = 1 + int'((exp_addr[i] - exp_addr[i-1]) / 4);
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != req) begin
                failures++;
                $display("FAIL basic_interval%0d: got %0d required %0d", i,
                         obs_cyc[i] - obs_cyc[i-1], req);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        for (int i = 0; i < 3; i++) ram[i] = $urandom() | 32'h1;
        d0 = ram[0];
        dump_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (dump_valid !== 1'b1 || dump_data !== d0 || dump_addr !== 8'd0 ||
                mem_enable !== 1'b0 || mem_address !== 8'd0) begin
                failures++;
                $display("FAIL stall_cycle%0d: v=%0b data=%h addr=%0d en=%0b maddr=%0d required 1/%h/0/0/0",
                         c, dump_valid, dump_data, dump_addr, mem_enable, mem_address, d0);
            end
            step();
        end
        dump_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) step();
        dump_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || words_sent !== 7'd3) begin
            failures++;
            $display("FAIL stall_finish: done=%0b ws=%0d required 1/3", done, words_sent);
        end
        step();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) ram[i] = $urandom() | 32'h100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        dump_ready = 1'b1;
        step();
        dump_ready = 1'b0;
        step();
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 8'd4) begin
            failures++;
            $display("FAIL abort_setup: v=%0b addr=%0d required 1/4", dump_valid, dump_addr);
        end
        abort = 1'b1;
        dump_ready = 1'b1;
        step();
        abort = 1'b0;
        dump_ready = 1'b0;
        checks++;
        if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words_sent !== 7'd1) begin
            failures++;
            $display("FAIL abort_state: v=%0b busy=%0b done=%0b ws=%0d required 0/0/0/1",
                     dump_valid, busy, done, words_sent);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle%0d: done=%0b busy=%0b required 0/0", c, done, busy);
            end
        end
        build_expected();
        run_collect(70);
        compare_beats("restart");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) ram[i] = $urandom() | 32'h1;
        start = 1'b1;
        step();
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_enable !== 1'b0 || dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            words_sent !== '0 || mem_address !== '0 || dump_data !== '0 || dump_addr !== '0 ||
            mem_size !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: en=%0b v=%0b busy=%0b ws=%0d maddr=%0d data=%h required all 0",
                     mem_enable, dump_valid, busy, words_sent, mem_address, dump_data);
        end
        #2;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_enable !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%0b done=%0b en=%0b required 0/0/0", busy, done, mem_enable);
        end
        // Start again, stall on the first beat and pulse start while busy.
        dump_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 8'd0 || mem_address !== 8'd0 || words_sent !== 7'd0) begin
            failures++;
            $display("FAIL start_while_busy: v=%0b addr=%0d maddr=%0d ws=%0d required 1/0/0/0",
                     dump_valid, dump_addr, mem_address, words_sent);
        end
        dump_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) step();
        dump_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || words_sent !== 7'd3) begin
            failures++;
            $display("FAIL busy_dump_finish: done=%0b ws=%0d required 1/3", done, words_sent);
        end
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 3; i++) ram[i] = ($urandom_range(99) < 30) ? 32'h0 : $urandom();
            build_expected();
            run_collect(int'($urandom_range(100, 30)));
            compare_beats("random");
        end
        for (int i = 0; i < 3; i++) ram[i] = 32'h0;
        build_expected();
        run_collect(100);
        compare_beats("all_zero");
    endtask

    task automatic test_last_word();
        logic [31:0] d;
        d = $urandom() | 32'h1;
        ram[63] = d;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if (mem_enable2 !== 1'b1 || mem_address2 !== 8'd252) begin
            failures++;
            $display("FAIL last_issue: en=%0b maddr=%0d required 1/252", mem_enable2, mem_address2);
        end
        step();
        checks++;
        if (dump_valid2 !== 1'b1 || dump_addr2 !== 8'd252 || dump_data2 !== d) begin
            failures++;
            $display("FAIL last_beat: v=%0b addr=%0d data=%h required 1/252/%h",
                     dump_valid2, dump_addr2, dump_data2, d);
        end
        dump_ready2 = 1'b1;
        step();
        dump_ready2 = 1'b0;
        checks++;
        if (done2 !== 1'b1 || dump_valid2 !== 1'b0 || words_sent2 !== 7'd1) begin
            failures++;
            $display("FAIL last_done: done=%0b v=%0b ws=%0d required 1/0/1", done2, dump_valid2, words_sent2);
        end
        step();
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || mem_address2 !== 8'd252) begin
            failures++;
            $display("FAIL last_nowrap: busy=%0b done=%0b maddr=%0d required 0/0/252", busy2, done2, mem_address2);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = $urandom();
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; dump_ready2 = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        test_last_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_dump_reader.md
Name: ram_dump_reader

Overview:
- Hardware reader for the data RAM that the pipeline's MEM stage writes.
- On a Start pulse, walks a word-aligned address window and reads each 32-bit word through the RAM read port.
- Streams each word out with its byte address over a valid/ready interface to a host or UART bridge.
- Replaces the simulation-only RAM dump with a synthesizable end-of-program readout.

Parameters:
- ADDR_W, 8, RAM byte-address width (matches the 8-bit RAM Address port).
- START_ADDR, 0, first word byte address; must be a multiple of 4.
- END_ADDR, 252, last word byte address, inclusive; must be a multiple of 4 and ≥ START_ADDR.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- Abort  input  1  cancels a dump in progress; returns to IDLE next edge.
- Mem_Enable  output  1  RAM access strobe.
- Mem_ReadWrite  output  1  constant 0 (read).
- Mem_Size  output  1  constant 1 (word access).
- Mem_Address  output  ADDR_W  current word byte address.
- Mem_DataOut  input  32  combinational RAM read data.
- Dump_Valid  output  1  Dump_Data and Dump_Addr are valid.
- Dump_Ready  input  1  consumer accepts the word.
- Dump_Data  output  32  captured word.
- Dump_Addr  output  ADDR_W  byte address of Dump_Data.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle pulse when the window completes.
- Words_Sent  output  ADDR_W-1  count of accepted words in the last or current dump.

Behaviour:
- Reset (asynchronous, Reset=0) sets all outputs to 0 and the state to IDLE.
  - This includes Mem_Enable, Mem_Address, Dump_Valid, Dump_Data, Dump_Addr, Busy, Done and Words_Sent.
  - Mem_Size is the only exception: it is constant 1.
  - Reset mid-dump discards the dump with no Done pulse.
- The FSM has four states: IDLE, ISSUE, PRESENT, DONE.
- IDLE:
  - Start=1 loads cur=START_ADDR, clears Words_Sent and goes to ISSUE.
  - Start is ignored in every other state.
- ISSUE (one cycle):
  - Mem_Enable=1 and Mem_Address=cur.
  - At the clock edge, Dump_Data<=Mem_DataOut and Dump_Addr<=cur, then go to PRESENT.
  - Read latency is 1 cycle from ISSUE entry to Dump_Valid.
- PRESENT:
  - Dump_Valid=1; Dump_Data and Dump_Addr hold stable until Dump_Ready=1.
  - On handshake, Words_Sent increments.
  - If cur==END_ADDR, go to DONE; otherwise cur<=cur+4 and go to ISSUE.
  - Back-to-back throughput is one word per 2 cycles.
- DONE: Done=1 for one cycle, then IDLE. Words_Sent holds until the next Start.
- Abort in ISSUE or PRESENT:
  - Next edge goes to IDLE with Dump_Valid=0 and no Done pulse.
  - Words_Sent holds its partial count.
  - If Abort and the handshake occur in the same cycle, Abort wins and the word is not counted.
- Boundaries:
  - The compare is done before the increment, so END_ADDR = 2^ADDR_W−4 never wraps cur.
  - START_ADDR==END_ADDR yields exactly one word.
  - Dump_Ready held low stalls indefinitely with no timeout.
- Mem_Enable is 0 outside ISSUE. The block never writes the RAM.

Optional Feature:
- Macro: DUMP_SKIP_ZERO_EN.
- Defined:
  - At the ISSUE edge, a Mem_DataOut==32'h0 word is not presented.
  - If cur==END_ADDR, go to DONE; otherwise cur<=cur+4 and go straight back to ISSUE.
  - Skipped words are not counted.
  - An all-zero window gives Done with Words_Sent=0 and no Dump_Valid.
- Undefined: every word in the window is presented.

Decomposition:
- Shared header/package dump_pkg holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, PRESENT=2'd2, DONE=2'd3;
  - WORD_BYTES=4;
  - MEM_RW_READ=1'b0 and MEM_SIZE_WORD=1'b1.
- One natural sub-module, dump_addr_ctr: loadable +4 address counter with a last-address compare output, reused by a future hardware program loader.

Test Plan:
1. Preload RAM words 0,4,8 = 32'hDEADBEEF, 32'h00000000, 32'h12345678; START_ADDR=0, END_ADDR=8; Dump_Ready=1; pulse Start.
   - Required: three beats (addr 0/DEADBEEF, 4/00000000, 8/12345678), one word per 2 cycles.
   - Then Done pulses once, Words_Sent=3, Busy falls.
2. Same preload with DUMP_SKIP_ZERO_EN defined.
   - Required: two beats (addr 0, 8), Words_Sent=2.
3. Backpressure: hold Dump_Ready=0 for 5 cycles on the first beat.
   - Required: Dump_Valid, Dump_Data and Dump_Addr stable throughout; Mem_Enable=0; no address advance.
4. Abort in PRESENT at addr 4.
   - Required: Dump_Valid=0 next cycle, state IDLE, no Done, Words_Sent=1.
   - A new Start restarts at addr 0.
5. Drive Reset=0 asynchronously mid-ISSUE.
   - Required: all outputs 0 immediately, without waiting for Clk; Start during Busy ignored afterwards.
6. START_ADDR=END_ADDR=252: exactly one beat at addr 252, then Done, with no address wrap.
